switchover_sequencer: RTL and testbench

Controller for the switchover clock selector, clocked by the second (target) clock. It waits for the second clock's source to report lock, enforces a settle period, and then requests the switchover. It confirms completion through the selector's acknowledge and reports timeouts. It sits beside the selector in the clock-generation subsystem and drives the selector's switch-enable input.

---
 rtl/switchover_sequencer.sv | 117 +++++++++++
 tb/tb_switchover_sequencer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/switchover_sequencer.sv
// Switchover sequencer: waits for second-clock lock, settles, requests the switch, confirms via ack.
// Optional SWITCHOVER_SEQUENCER_FALLBACK_EN: lock loss while RUNNING releases the switch (RELEASE state).
module switchover_sequencer #(
  parameter int SYNC_STAGES   = 2,
  parameter int SETTLE_CYCLES = 64,
  parameter int ACK_TIMEOUT   = 16
) (
  input  logic       second_clock,
  input  logic       resetn,
  input  logic       pll_locked,
  input  logic       hold,
  input  logic       switch_ack,
  output logic       switch_request,
  output logic       switched,
  output logic       timeout_error,
  output logic       lock_lost,
  output logic [2:0] state
);

  localparam int MAX_CNT = (SETTLE_CYCLES > ACK_TIMEOUT) ? SETTLE_CYCLES : ACK_TIMEOUT;
  localparam int CW      = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    SETTLE    = 3'd1,
    REQUEST   = 3'd2,
    RUNNING   = 3'd3,
    RELEASE   = 3'd4,
    ERROR     = 3'd5,
    HOLD      = 3'd6
  } state_t;

  // Handshake: switch_request is a level; the selector answers with switch_ack
  // as a level (1 = running on second_clock). A request may only be dropped
  // after ack, and the ack must follow each edge within ACK_TIMEOUT cycles.

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   locked_s;
  state_t                 state_q;
  state_t                 state_d;
  logic [CW-1:0]          cnt_q;
  logic                   set_lost;

  assign locked_s = sync_q[SYNC_STAGES-1];
  assign state    = state_q;

  always_ff @(posedge second_clock or negedge resetn) begin
    if (!resetn) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
    end
  end

  always_comb begin
    state_d  = state_q;
    set_lost = 1'b0;
    case (state_q)
      WAIT_LOCK: begin
        if (hold)          state_d = HOLD;
        else if (locked_s) state_d = SETTLE;
      end
      HOLD: begin
        if (!hold) state_d = WAIT_LOCK;
      end
      SETTLE: begin
        if (hold)                                   state_d = HOLD;
        else if (!locked_s)                         state_d = WAIT_LOCK;
        else if (cnt_q == CW'(SETTLE_CYCLES - 1))   state_d = REQUEST;
      end
      REQUEST: begin
        if (switch_ack)                           state_d = RUNNING;
        else if (cnt_q == CW'(ACK_TIMEOUT - 1))   state_d = ERROR;
      end
      RUNNING: begin
        if (!locked_s) begin
          set_lost = 1'b1;
`ifdef SWITCHOVER_SEQUENCER_FALLBACK_EN
          state_d  = RELEASE;
`endif
        end
      end
`ifdef SWITCHOVER_SEQUENCER_FALLBACK_EN
      RELEASE: begin
        if (!switch_ack)                          state_d = WAIT_LOCK;
        else if (cnt_q == CW'(ACK_TIMEOUT - 1))   state_d = ERROR;
      end
`endif
      ERROR:   state_d = ERROR;
      default: state_d = WAIT_LOCK;
    endcase
  end

  // Outputs are decoded from the next state so they move on the same edge as state.
  always_ff @(posedge second_clock or negedge resetn) begin
    if (!resetn) begin
      state_q        <= WAIT_LOCK;
      cnt_q          <= '0;
      switch_request <= 1'b0;
      switched       <= 1'b0;
      timeout_error  <= 1'b0;
      lock_lost      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q) begin
        cnt_q <= '0;
      end else if (cnt_q != {CW{1'b1}}) begin
        cnt_q <= cnt_q + 1'b1;
      end
      switch_request <= (state_d == REQUEST) || (state_d == RUNNING);
      switched       <= (state_d == RUNNING);
      if ((state_d == ERROR) && (state_q != ERROR)) timeout_error <= 1'b1;
      if (set_lost) lock_lost <= 1'b1;
    end
  end

endmodule

// File: tb/tb_switchover_sequencer.sv
// Self-checking bench for switchover_sequencer (SYNC_STAGES=2, SETTLE_CYCLES=8, ACK_TIMEOUT=4).
// Observation word: {state[2:0], switch_request, switched, timeout_error, lock_lost}.
module tb_switchover_sequencer;

  logic       second_clock = 1'b0;
  logic       resetn = 1'b0;
  logic       pll_locked = 1'b0;
  logic       hold = 1'b0;
  logic       switch_ack = 1'b0;
  logic       switch_request;
  logic       switched;
  logic       timeout_error;
  logic       lock_lost;
  logic [2:0] state;

  int n_cmp = 0;
  int n_err = 0;
  logic [6:0] exp_q[$];
  logic [6:0] obs;

  assign obs = {state, switch_request, switched, timeout_error, lock_lost};

  switchover_sequencer #(
    .SYNC_STAGES  (2),
    .SETTLE_CYCLES(8),
    .ACK_TIMEOUT  (4)
  ) dut (
    .second_clock  (second_clock),
    .resetn        (resetn),
    .pll_locked    (pll_locked),
    .hold          (hold),
    .switch_ack    (switch_ack),
    .switch_request(switch_request),
    .switched      (switched),
    .timeout_error (timeout_error),
    .lock_lost     (lock_lost),
    .state         (state)
  );

  // clock / reset
  always #5 second_clock = ~second_clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [6:0] e(input logic [2:0] st, input logic rq, input logic sw,
                                   input logic te, input logic ll);
    return {st, rq, sw, te, ll};
  endfunction

  task automatic check_eq(input string tag, input logic [6:0] got, input logic [6:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b required %b", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge second_clock);
      #1;
    end
  endtask

  // push the expectation, advance n edges, then pop and compare against the DUT
  task automatic step(input int n, input logic [6:0] exp, input string tag);
    logic [6:0] want;
    exp_q.push_back(exp);
    tick(n);
    if (exp_q.size() == 0) begin
      check_eq({tag, "_empty"}, obs, ~obs);
    end else begin
      want = exp_q.pop_front();
      check_eq(tag, obs, want);
    end
  endtask

  task automatic wait_state(input logic [2:0] target, input int budget, input string tag);
    int i;
    i = 0;
    while (state !== target && i < budget) begin
      tick(1);
      i++;
    end
    check_eq(tag, {4'd0, state}, {4'd0, target});
  endtask

  task automatic do_reset(input logic lock_val);
    resetn     = 1'b0;
    switch_ack = 1'b0;
    hold       = 1'b0;
    pll_locked = lock_val;
    tick(2);
    @(negedge second_clock);
    resetn = 1'b1;
  endtask

  initial begin
    // nominal switchover
    do_reset(1'b1);
    check_eq("reset_state", obs, e(3'd0, 0, 0, 0, 0));
    step(2, e(3'd0, 0, 0, 0, 0), "nom_edge2_wait");
    step(1, e(3'd1, 0, 0, 0, 0), "nom_edge3_settle");
    step(7, e(3'd1, 0, 0, 0, 0), "nom_edge10_settle");
    step(1, e(3'd2, 1, 0, 0, 0), "nom_edge11_request");
    step(3, e(3'd2, 1, 0, 0, 0), "nom_edge14_request");
    switch_ack = 1'b1;
    // ack sampled on the same edge the timeout count expires: ack must win
    step(1, e(3'd3, 1, 1, 0, 0), "nom_edge15_running");

    // lock loss in RUNNING
    pll_locked = 1'b0;
    step(2, e(3'd3, 1, 1, 0, 0), "lost_sync_delay");
`ifdef SWITCHOVER_SEQUENCER_FALLBACK_EN
    step(1, e(3'd4, 0, 0, 0, 1), "lost_release");
    switch_ack = 1'b0;
    step(1, e(3'd0, 0, 0, 0, 1), "lost_ack_drop");
    pll_locked = 1'b1;
    wait_state(3'd2, 30, "relock_request");
    switch_ack = 1'b1;
    step(1, e(3'd3, 1, 1, 0, 1), "relock_running");
`else
    step(1, e(3'd3, 1, 1, 0, 1), "lost_absorbing");
    pll_locked = 1'b1;
    step(3, e(3'd3, 1, 1, 0, 1), "lost_sticky");
`endif

    // async reset while RUNNING
    #2;
    resetn = 1'b0;
    #1;
    check_eq("async_reset", obs, e(3'd0, 0, 0, 0, 0));

    // lock glitch at settle count 5, then ack timeout
    do_reset(1'b1);
    step(8, e(3'd1, 0, 0, 0, 0), "glitch_settle5");
    pll_locked = 1'b0;
    step(2, e(3'd1, 0, 0, 0, 0), "glitch_low");
    pll_locked = 1'b1;
    step(1, e(3'd0, 0, 0, 0, 0), "glitch_restart");
    step(9, e(3'd1, 0, 0, 0, 0), "glitch_edge20_settle");
    step(1, e(3'd2, 1, 0, 0, 0), "glitch_edge21_request");
    step(3, e(3'd2, 1, 0, 0, 0), "tmo_edge24_request");
    step(1, e(3'd5, 0, 0, 1, 0), "tmo_edge25_error");
    hold       = 1'b1;
    switch_ack = 1'b1;
    step(5, e(3'd5, 0, 0, 1, 0), "tmo_terminal");
    resetn = 1'b0;
    #1;
    check_eq("tmo_reset_clears", obs, e(3'd0, 0, 0, 0, 0));

    // hold during SETTLE
    do_reset(1'b1);
    step(5, e(3'd1, 0, 0, 0, 0), "hold_settle");
    hold = 1'b1;
    step(1, e(3'd6, 0, 0, 0, 0), "hold_enter");
    step(3, e(3'd6, 0, 0, 0, 0), "hold_stay");
    hold = 1'b0;
    step(1, e(3'd0, 0, 0, 0, 0), "hold_exit_wait");
    step(1, e(3'd1, 0, 0, 0, 0), "hold_resettle");
    step(7, e(3'd1, 0, 0, 0, 0), "hold_settle_full");
    step(1, e(3'd2, 1, 0, 0, 0), "hold_request");
    hold = 1'b1;
    step(1, e(3'd2, 1, 0, 0, 0), "hold_ignored_request");

    // hold taken straight from WAIT_LOCK
    do_reset(1'b0);
    hold = 1'b1;
    step(1, e(3'd6, 0, 0, 0, 0), "hold_from_wait");

    if (exp_q.size() != 0) check_eq("queue_drained", 7'(exp_q.size()), 7'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
